lfsr_gen: RTL and testbench

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen.sv | 138 +++++++++++++
 tb/tb_lfsr_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR sample source with a valid/ready output slot,
// all-zero lockup recovery and a period marker.
module lfsr_gen #(
    parameter int          WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h9C,
    parameter logic [31:0] SEED  = 32'hBC,
    parameter int          MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             lockup,
    output logic             period_done,
    output logic [1:0]       dbg_state
);

    // Handshake: a sample transfers in any cycle where data_valid and data_ready
    // are both high at the rising edge; data_out is stable while data_valid is
    // high and not yet accepted.

    if (WIDTH < 3 || WIDTH > 32 || TAPS == 0 || SEED == 0 || MODE < 0 || MODE > 1) begin : g_bad_param
        $error("lfsr_gen: illegal parameters WIDTH=%0d TAPS=%0h SEED=%0h MODE=%0d",
               WIDTH, TAPS, SEED, MODE);
    end

    localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V = SEED[WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RECOVER = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             lockup_q, lockup_d;
    logic             period_done_q, period_done_d;

    logic [WIDTH-1:0] fib_next, gal_next, lfsr_next, seed_eff;
    logic             slot_free, is_zero, step;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q         <= ST_RUN;
            state_q       <= SEED_V;
            start_q       <= SEED_V;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            lockup_q      <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            start_q       <= start_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            lockup_q      <= lockup_d;
            period_done_q <= period_done_d;
        end
    end

    always_comb begin
        fib_next  = {state_q[WIDTH-2:0], ^(state_q & TAP_M)};
        gal_next  = {state_q[WIDTH-2:0], 1'b0} ^ (TAP_M & {WIDTH{state_q[WIDTH-1]}});
        lfsr_next = (MODE == 1) ? gal_next : fib_next;
        seed_eff  = (seed_in == '0) ? SEED_V : seed_in;
        slot_free = !data_valid_q || data_ready;
        is_zero   = (state_q == '0);
        // HOLD only ever has data_valid set, so slot_free there means data_ready.
        step      = !load && enable && slot_free && !is_zero && (fsm_q != ST_RECOVER);
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        if (load) begin
            fsm_d = ST_RUN;
        end else begin
            case (fsm_q)
                ST_RUN: begin
                    if (is_zero)                                  fsm_d = ST_RECOVER;
                    else if (data_valid_q && !data_ready && enable) fsm_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (is_zero)         fsm_d = ST_RECOVER;
                    else if (data_ready) fsm_d = ST_RUN;
                end
                ST_RECOVER: fsm_d = ST_RUN;
                default:    fsm_d = ST_RUN;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        lockup_d      = 1'b0;
        period_done_d = 1'b0;
        if (load) begin
            state_d      = seed_eff;
            start_d      = seed_eff;
            data_valid_d = 1'b0;
            lockup_d     = (seed_in == '0);
        end else if (fsm_q == ST_RECOVER) begin
            state_d      = SEED_V;
            start_d      = SEED_V;
            data_valid_d = 1'b0;
            lockup_d     = 1'b1;
        end else if (step) begin
            state_d       = lfsr_next;
            data_out_d    = state_q;
            data_valid_d  = 1'b1;
            period_done_d = (lfsr_next == start_q);
        end else if (slot_free) begin
            data_valid_d = 1'b0;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign lockup      = lockup_q;
    assign period_done = period_done_q;
    assign dbg_state   = fsm_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: default 8-bit instance driven through handshake,
// load, lockup and reset scenarios, plus two free-running 4-bit instances.
module tb_lfsr_gen;

    logic clk;
    logic reset, rst4;
    logic enable, load, data_ready;
    logic [7:0] seed_in;
    logic [7:0] data_out;
    logic data_valid, lockup, period_done;
    logic [1:0] dbg_state;

    logic one, zero;
    logic [3:0] seed4;
    logic [3:0] dout_f, dout_g;
    logic valid_f, valid_g, lock_f, lock_g, pd_f, pd_g;
    logic [1:0] dbg_f, dbg_g;

    int n_vec, n_err;
    logic [7:0] exp_q[$];
    logic [7:0] last_pop;

    localparam logic [7:0] SEED8 = 8'hBC;

    lfsr_gen dut0 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .lockup(lockup), .period_done(period_done), .dbg_state(dbg_state)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(32'hC), .SEED(32'h1), .MODE(0)) dut_f (
        .clk(clk), .reset(rst4), .enable(one), .load(zero), .seed_in(seed4),
        .data_out(dout_f), .data_valid(valid_f), .data_ready(one),
        .lockup(lock_f), .period_done(pd_f), .dbg_state(dbg_f)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(32'h9), .SEED(32'h1), .MODE(1)) dut_g (
        .clk(clk), .reset(rst4), .enable(one), .load(zero), .seed_in(seed4),
        .data_out(dout_g), .data_valid(valid_g), .data_ready(one),
        .lockup(lock_g), .period_done(pd_g), .dbg_state(dbg_g)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w,
                                              input logic [31:0] taps, input int mode);
        logic [31:0] mask, r;
        mask = (32'h1 << w) - 32'h1;
        if (mode == 0) begin
            r = ((s << 1) | {31'b0, ^(s & taps)}) & mask;
        end else begin
            r = (s << 1) & mask;
            if (s[w-1]) r = r ^ (taps & mask);
        end
        return r;
    endfunction

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [31:0] s;
        s = {24'b0, start};
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[7:0]);
            s = lfsr_step(s, 8, 32'h9C, 0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for the default instance: pop on every accepted sample
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                last_pop = exp_q.pop_front();
                check("sb_sample", 32'(data_out), 32'(last_pop));
            end
        end
    end

    // Bit-accurate models for the free-running 4-bit instances
    logic [31:0] mf, mg;
    int idx_f, idx_g, last_f, last_g, cnt_f, cnt_g;

    always @(negedge clk) begin
        if (!rst4 && valid_f) begin
            check("fib4_data", 32'(dout_f), mf);
            check("fib4_pd", 32'(pd_f), 32'(lfsr_step(mf, 4, 32'hC, 0) == 32'h1));
            check("fib4_lock", 32'(lock_f), 32'd0);
            if (pd_f) begin
                if (cnt_f > 0) check("fib4_interval", 32'(idx_f - last_f), 32'd15);
                else           check("fib4_first_pd", 32'(idx_f), 32'd14);
                last_f = idx_f;
                cnt_f++;
            end
            mf = lfsr_step(mf, 4, 32'hC, 0);
            idx_f++;
        end
        if (!rst4 && valid_g) begin
            check("gal4_data", 32'(dout_g), mg);
            check("gal4_pd", 32'(pd_g), 32'(lfsr_step(mg, 4, 32'h9, 1) == 32'h1));
            check("gal4_dbg", 32'(dbg_g), 32'd0);
            if (pd_g) begin
                if (cnt_g > 0) check("gal4_interval", 32'(idx_g - last_g), 32'd15);
                else           check("gal4_first_pd", 32'(idx_g), 32'd14);
                last_g = idx_g;
                cnt_g++;
            end
            mg = lfsr_step(mg, 4, 32'h9, 1);
            idx_g++;
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        mf = 32'h1; mg = 32'h1;
        idx_f = 0; idx_g = 0; last_f = 0; last_g = 0; cnt_f = 0; cnt_g = 0;
        last_pop = 8'h00;
        one = 1'b1; zero = 1'b0; seed4 = 4'h0;
        reset = 1'b1; rst4 = 1'b1;
        enable = 1'b1; load = 1'b0; seed_in = 8'h00; data_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_lockup", 32'(lockup), 32'd0);
        check("rst_pd", 32'(period_done), 32'd0);
        check("rst_dbg", 32'(dbg_state), 32'd0);
        check("rst4_valid", 32'(valid_f), 32'd0);

        push_seq(SEED8, 20);
        reset = 1'b0; rst4 = 1'b0;

        // First sample, then consumer stalls for five cycles
        tick(1);
        check("first_valid", 32'(data_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", 32'(data_out), 32'(SEED8));
            tick(1);
        end
        check("hold_state", 32'(dbg_state), 32'd1);
        data_ready = 1'b1;
        tick(8);

        // Enable low: sample freezes, valid drops once consumed
        enable = 1'b0;
        tick(1);
        check("en0_valid", 32'(data_valid), 32'd0);
        check("en0_data", 32'(data_out), 32'(last_pop));
        tick(2);
        check("en0_data2", 32'(data_out), 32'(last_pop));
        enable = 1'b1;
        tick(4);

        // Load of zero falls back to SEED with a lockup pulse
        seed_in = 8'h00; load = 1'b1;
        tick(1);
        load = 1'b0;
        exp_q.delete();
        push_seq(SEED8, 20);
        check("ld0_valid", 32'(data_valid), 32'd0);
        check("ld0_lockup", 32'(lockup), 32'd1);
        tick(1);
        check("ld0_lockup_end", 32'(lockup), 32'd0);
        check("ld0_first", 32'(data_out), 32'(SEED8));
        tick(3);

        seed_in = 8'h5A; load = 1'b1;
        tick(1);
        load = 1'b0;
        exp_q.delete();
        push_seq(8'h5A, 20);
        check("ld5a_valid", 32'(data_valid), 32'd0);
        check("ld5a_lockup", 32'(lockup), 32'd0);
        tick(1);
        check("ld5a_first", 32'(data_out), 32'h5A);
        tick(3);

        // Upset: state forced to zero
        dut0.state_q = 8'h00;
        @(negedge clk); #1;
        exp_q.delete();
        push_seq(SEED8, 20);
        @(posedge clk); #1;
        check("rec_state", 32'(dbg_state), 32'd2);
        check("rec_valid", 32'(data_valid), 32'd0);
        check("rec_lock_early", 32'(lockup), 32'd0);
        tick(1);
        check("rec_lockup", 32'(lockup), 32'd1);
        check("rec_valid2", 32'(data_valid), 32'd0);
        tick(1);
        check("rec_lock_end", 32'(lockup), 32'd0);
        check("rec_first", 32'(data_out), 32'(SEED8));
        tick(4);

        // Reset asserted while in HOLD
        data_ready = 1'b0;
        tick(2);
        check("hold2_state", 32'(dbg_state), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_data", 32'(data_out), 32'd0);
        check("arst_valid", 32'(data_valid), 32'd0);
        check("arst_lockup", 32'(lockup), 32'd0);
        check("arst_pd", 32'(period_done), 32'd0);
        check("arst_dbg", 32'(dbg_state), 32'd0);
        exp_q.delete();
        push_seq(SEED8, 20);
        data_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        check("arst_first", 32'(data_out), 32'(SEED8));
        check("arst_first_v", 32'(data_valid), 32'd1);
        tick(12);

        check("fib4_pulses", 32'(cnt_f), 32'(idx_f / 15));
        check("gal4_pulses", 32'(cnt_g), 32'(idx_g / 15));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
